uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serialises 8-bit bytes onto the UART Tx line. Frame: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1). It is the transmit counterpart of the UART_Receiver and uses the same baud/clock parameterisation and parity convention, so its frames loop back into the receiver with no errors. A one-entry holding register allows a byte to be queued while a frame is in flight, giving back-to-back frames with no idle gap.

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits/s; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division; 5208 at defaults)
PARITY_EN, 1, 1 = parity bit present (11-bit frame); 0 = no parity (10-bit frame)
PARITY_ODD, 0, 0 = even parity; 1 = odd parity

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
enable  in  1  1 = may start new frames
data_in  in  8  byte to send
data_valid  in  1  data_in valid this cycle
data_ready  out  1  holding register empty; byte accepted when data_valid && data_ready at posedge
Tx  out  1  serial line, registered, idle high
transmitting  out  1  1 while the FSM is not in IDLE
bits_sent  out  4  data bits completed in the current frame, 0..8
BAUD_counter  out  16  cycle count within the current bit, 0..CLKS_PER_BIT-1
tx_done  out  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset (async, nRst=0) forces: Tx=1, data_ready=1, transmitting=0, bits_sent=0, BAUD_counter=0, tx_done=0, holding register empty, FSM=IDLE. A reset mid-frame aborts the frame and returns Tx high immediately.
- Holding register: loaded at the accept edge. data_ready = holding empty. data_valid while data_ready=0 is ignored; the input is not stalled or latched.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START at the first posedge where the holding register is full and enable=1. At that edge the byte moves into the shift register, the holding register empties (data_ready=1 on the next cycle) and Tx=0. Latency is one cycle from the accept edge to Tx falling.
- Bit timing: each state holds Tx for exactly CLKS_PER_BIT cycles. BAUD_counter increments every cycle, wraps to 0 on the last cycle of a bit, and the state advances at that wrap.
- START -> DATA.
- DATA: Tx = shift[0]; the register shifts right at each bit end; bits_sent increments at each bit end. After the 8th bit: PARITY if PARITY_EN, else STOP.
- PARITY: Tx = ^byte XOR PARITY_ODD.
- STOP: Tx=1. At the end of the stop bit, tx_done=1 for one cycle. If the holding register is full and enable=1, go directly to START (Tx 1->0, zero gap). Otherwise go to IDLE.
- bits_sent clears to 0 on entry to START. BAUD_counter is held at 0 in IDLE.
- Frame length: 11*CLKS_PER_BIT cycles with parity, 10*CLKS_PER_BIT without.
- enable=0 blocks only frame starts. A frame already in progress completes unchanged, and acceptance into the holding register continues.
- Acceptance during the transfer edge: data_ready is still 0 on that edge, so no accept occurs; acceptance resumes on the following cycle.

Test Plan:
- Reset: assert nRst=0 mid-frame -> Tx=1, data_ready=1, transmitting=0, bits_sent=0 within the same cycle; no tx_done pulse.
- Single byte 0x55, defaults -> Tx sequence 0,1,0,1,0,1,0,1,0,0(parity),1, each level held exactly 5208 cycles; tx_done pulses once, 57288 cycles after Tx falls; bits_sent reaches 8.
- Parity: byte 0x07 (CLOCK_FREQ=1000000, BAUD_RATE=100000, CLKS_PER_BIT=10) -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1. With PARITY_EN=0 -> frame is 100 cycles with no parity slot.
- Back-to-back: accept 0xA5, then accept 0x3C while the first frame is in flight -> data_ready=0 until the second byte transfers; the second start bit begins the cycle after the first stop bit ends (no idle); a third data_valid while full is ignored.
- Enable gating: enable=0 with a byte queued -> Tx stays 1 and transmitting=0; raising enable -> Tx falls on the next posedge. Dropping enable mid-frame -> the frame completes fully.
- Loopback: connect Tx to a UART_Receiver with the same parameters and send 0x00, 0xFF, 0x81 -> receiver data_out matches each byte and parity_error=0.

Source files
------------

// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// Latency: Tx falls one cycle after a byte is accepted when idle; queued bytes follow with no gap.
// Backpressure: data_ready drops while the one-entry holding register is full; data_valid is ignored then.
module uart_transmitter #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        enable,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic        Tx,
   output logic        transmitting,
   output logic [3:0]  bits_sent,
   output logic [15:0] BAUD_counter,
   output logic        tx_done
);

   localparam int          CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam logic [15:0] LAST_CNT     = 16'(CLKS_PER_BIT - 1);
   localparam logic        ODD_BIT      = (PARITY_ODD != 0);
   localparam logic        HAS_PARITY   = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t      state, state_nxt;

   // Datapath registers and their next values
   logic [15:0] baud_cnt, baud_nxt;
   logic [3:0]  bit_cnt, bit_nxt;
   logic [7:0]  shift_reg, shift_nxt;
   logic        par_bit, par_nxt;
   logic [7:0]  hold_dat, hold_dat_nxt;
   logic        hold_vld, hold_vld_nxt;
   logic        tx_q, tx_nxt;
   logic        done_q, done_nxt;

   logic        bit_end;
   logic        can_start;
   logic        load;

   // Last cycle of the current bit period; the FSM only advances here
   assign bit_end   = (baud_cnt == LAST_CNT);
   // A frame may start only with a queued byte and the gate open
   assign can_start = hold_vld && enable;

   // State register
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, bit timing, shifting and holding-register control
   always_comb begin
      state_nxt    = state;
      baud_nxt     = baud_cnt;
      bit_nxt      = bit_cnt;
      shift_nxt    = shift_reg;
      par_nxt      = par_bit;
      hold_dat_nxt = hold_dat;
      hold_vld_nxt = hold_vld;
      tx_nxt       = tx_q;
      done_nxt     = 1'b0;
      load         = 1'b0;

      // Bit-period counter runs in every non-idle state and wraps at the bit end
      if (state == IDLE) begin
         baud_nxt = 16'd0;
      end else if (bit_end) begin
         baud_nxt = 16'd0;
      end else begin
         baud_nxt = baud_cnt + 16'd1;
      end

      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (can_start) begin
               load = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               tx_nxt    = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_nxt = {1'b0, shift_reg[7:1]};
               bit_nxt   = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  if (HAS_PARITY) begin
                     state_nxt = PARITY;
                     tx_nxt    = par_bit;
                  end else begin
                     state_nxt = STOP;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  // Next data bit is the one about to land in bit 0
                  tx_nxt = shift_reg[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               tx_nxt    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               done_nxt = 1'b1;
               if (can_start) begin
                  // Chain straight into the next start bit, no idle gap
                  load = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  tx_nxt    = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase

      // Move the queued byte into the shifter and begin a start bit.
      // Parity is captured here because the shifter is consumed as it goes.
      if (load) begin
         state_nxt    = START;
         shift_nxt    = hold_dat;
         par_nxt      = (^hold_dat) ^ ODD_BIT;
         bit_nxt      = 4'd0;
         tx_nxt       = 1'b0;
         hold_vld_nxt = 1'b0;
      end

      // Accept only when the holding register was empty at this edge; on a
      // transfer edge it is still full, so acceptance resumes next cycle.
      if (data_valid && !hold_vld) begin
         hold_vld_nxt = 1'b1;
         hold_dat_nxt = data_in;
      end
   end

   // Datapath registers; reset drives the line idle high at once
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         baud_cnt  <= 16'd0;
         bit_cnt   <= 4'd0;
         shift_reg <= 8'd0;
         par_bit   <= 1'b0;
         hold_dat  <= 8'd0;
         hold_vld  <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         baud_cnt  <= baud_nxt;
         bit_cnt   <= bit_nxt;
         shift_reg <= shift_nxt;
         par_bit   <= par_nxt;
         hold_dat  <= hold_dat_nxt;
         hold_vld  <= hold_vld_nxt;
         tx_q      <= tx_nxt;
         done_q    <= done_nxt;
      end
   end

   assign Tx           = tx_q;
   assign data_ready   = !hold_vld;
   assign transmitting = (state != IDLE);
   assign bits_sent    = bit_cnt;
   assign BAUD_counter = baud_cnt;
   assign tx_done      = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// Bench for uart_transmitter: three instances (even parity, odd parity, no parity)
// at 10 clocks per bit, driven from a table of bytes plus hand-written corner cases.
// Each frame is sampled every cycle and also decoded mid-bit like a receiver.
module tb_uart_transmitter;

   localparam int C = 10;

   logic        tb_clk = 1'b0;
   logic        nrst;
   logic        enable;
   logic [7:0]  data_in;
   logic        dv      [3];
   logic        dr_w    [3];
   logic        tx_w    [3];
   logic        tr_w    [3];
   logic [3:0]  bs_w    [3];
   logic [15:0] bc_w    [3];
   logic        done_w  [3];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] dat;
      logic       par_even;
      logic       par_odd;
   } vec_t;

   vec_t vecs [6];

   always #5 tb_clk = ~tb_clk;

   uart_transmitter #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .clk(tb_clk), .nRst(nrst), .enable(enable), .data_in(data_in), .data_valid(dv[0]),
      .data_ready(dr_w[0]), .Tx(tx_w[0]), .transmitting(tr_w[0]), .bits_sent(bs_w[0]),
      .BAUD_counter(bc_w[0]), .tx_done(done_w[0]));

   uart_transmitter #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .clk(tb_clk), .nRst(nrst), .enable(enable), .data_in(data_in), .data_valid(dv[1]),
      .data_ready(dr_w[1]), .Tx(tx_w[1]), .transmitting(tr_w[1]), .bits_sent(bs_w[1]),
      .BAUD_counter(bc_w[1]), .tx_done(done_w[1]));

   uart_transmitter #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
      .clk(tb_clk), .nRst(nrst), .enable(enable), .data_in(data_in), .data_valid(dv[2]),
      .data_ready(dr_w[2]), .Tx(tx_w[2]), .transmitting(tr_w[2]), .bits_sent(bs_w[2]),
      .BAUD_counter(bc_w[2]), .tx_done(done_w[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Offer a byte to instance k while idle; returns at the negedge where Tx has just fallen
   task automatic send_byte(input int k, input logic [7:0] b, input string tag);
      @(negedge tb_clk);
      chk({tag, "_rdy"}, 32'(dr_w[k]), 32'd1);
      data_in = b;
      dv[k]   = 1'b1;
      @(posedge tb_clk);
      #1 dv[k] = 1'b0;
      @(negedge tb_clk);
      chk({tag, "_lat_hi"}, 32'(tx_w[k]), 32'd1);
      @(negedge tb_clk);
      chk({tag, "_lat_lo"}, 32'(tx_w[k]), 32'd0);
   endtask

   // Sample one frame starting at the negedge where its start bit is visible;
   // returns at the negedge just after the stop bit ended.
   task automatic capture(input int k, input logic [7:0] b, input logic exp_par,
                          input logic pen, input logic podd, input logic next_tx,
                          input string tag);
      int   nslot;
      int   n;
      int   sl;
      int   ebs;
      int   cnt_err;
      int   done_err;
      int   err;
      logic exp_lvl;
      logic s_tx [110];
      logic [7:0] rx;
      logic rx_par;
      logic pe;
      nslot    = pen ? 11 : 10;
      n        = nslot * C;
      cnt_err  = 0;
      done_err = 0;
      for (int i = 0; i < n; i++) begin
         s_tx[i] = tx_w[k];
         sl  = i / C;
         ebs = (sl <= 1) ? 0 : ((sl - 1 > 8) ? 8 : sl - 1);
         if (bc_w[k] !== 16'(i % C) || bs_w[k] !== 4'(ebs) || tr_w[k] !== 1'b1) cnt_err++;
         if (i > 0 && done_w[k] !== 1'b0) done_err++;
         @(negedge tb_clk);
      end
      chk({tag, "_counters"}, 32'(cnt_err), 32'd0);
      chk({tag, "_done_early"}, 32'(done_err), 32'd0);
      chk({tag, "_done_pulse"}, 32'(done_w[k]), 32'd1);
      chk({tag, "_after_stop"}, 32'(tx_w[k]), 32'(next_tx));
      for (int s = 0; s < nslot; s++) begin
         if (s == 0)                exp_lvl = 1'b0;
         else if (s <= 8)           exp_lvl = b[s-1];
         else if (s == 9 && pen)    exp_lvl = exp_par;
         else                       exp_lvl = 1'b1;
         err = 0;
         for (int j = 0; j < C; j++) begin
            if (s_tx[s*C + j] !== exp_lvl) err++;
         end
         chk($sformatf("%s_slot%0d_badcycles", tag, s), 32'(err), 32'd0);
      end
      // Receiver-style decode at mid-bit
      for (int j = 0; j < 8; j++) rx[j] = s_tx[(j+1)*C + C/2];
      rx_par = s_tx[9*C + C/2];
      pe     = pen ? (((^rx) ^ rx_par) != podd) : 1'b0;
      chk({tag, "_rx_data"}, 32'(rx), 32'(b));
      chk({tag, "_rx_parity_err"}, 32'(pe), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int   errs;
      logic par;
      vecs[0] = '{8'h55, 1'b0, 1'b1};
      vecs[1] = '{8'h07, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 1'b0, 1'b1};
      vecs[4] = '{8'h81, 1'b0, 1'b1};
      vecs[5] = '{8'hB6, 1'b1, 1'b0};

      nrst    = 1'b0;
      enable  = 1'b1;
      data_in = 8'h00;
      for (int k = 0; k < 3; k++) dv[k] = 1'b0;

      repeat (3) @(negedge tb_clk);
      chk("reset_tx",    32'(tx_w[0]),  32'd1);
      chk("reset_ready", 32'(dr_w[0]),  32'd1);
      chk("reset_trans", 32'(tr_w[0]),  32'd0);
      chk("reset_bits",  32'(bs_w[0]),  32'd0);
      chk("reset_baud",  32'(bc_w[0]),  32'd0);
      chk("reset_done",  32'(done_w[0]), 32'd0);
      nrst = 1'b1;

      // Table: every byte through even, odd and no-parity instances
      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < 3; k++) begin
            string tag;
            tag = $sformatf("v%0d_d%0d", v, k);
            par = (k == 1) ? vecs[v].par_odd : vecs[v].par_even;
            send_byte(k, vecs[v].dat, tag);
            capture(k, vecs[v].dat, par, (k != 2), (k == 1), 1'b1, tag);
            @(negedge tb_clk);
            chk({tag, "_done_once"}, 32'(done_w[k]), 32'd0);
            chk({tag, "_idle_tx"}, 32'(tx_w[k]), 32'd1);
         end
      end

      // Back-to-back: queue 0x3C during 0xA5, third byte while full is dropped
      send_byte(0, 8'hA5, "b2b1");
      fork
         capture(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, "b2b1");
         begin
            repeat (3) @(negedge tb_clk);
            chk("b2b_rdy_inflight", 32'(dr_w[0]), 32'd1);
            data_in = 8'h3C;
            dv[0]   = 1'b1;
            @(negedge tb_clk);
            chk("b2b_full", 32'(dr_w[0]), 32'd0);
            data_in = 8'hEE;
            repeat (2) @(negedge tb_clk);
            dv[0] = 1'b0;
            repeat (11*C - 7) @(negedge tb_clk);
            chk("b2b_full_at_stop", 32'(dr_w[0]), 32'd0);
         end
      join
      chk("b2b_rdy_after_xfer", 32'(dr_w[0]), 32'd1);
      capture(0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, "b2b2");
      errs = 0;
      repeat (3*C) begin
         @(negedge tb_clk);
         if (tx_w[0] !== 1'b1 || tr_w[0] !== 1'b0) errs++;
      end
      chk("b2b_third_ignored", 32'(errs), 32'd0);
      chk("b2b_final_ready", 32'(dr_w[0]), 32'd1);

      // Enable gating: queued byte waits, then frame survives enable dropping
      @(negedge tb_clk);
      enable  = 1'b0;
      data_in = 8'h5A;
      dv[0]   = 1'b1;
      @(posedge tb_clk);
      #1 dv[0] = 1'b0;
      errs = 0;
      repeat (20) begin
         @(negedge tb_clk);
         if (tx_w[0] !== 1'b1 || tr_w[0] !== 1'b0 || dr_w[0] !== 1'b0) errs++;
      end
      chk("en_blocked", 32'(errs), 32'd0);
      enable = 1'b1;
      @(negedge tb_clk);
      chk("en_rise_tx", 32'(tx_w[0]), 32'd0);
      chk("en_rise_trans", 32'(tr_w[0]), 32'd1);
      fork
         capture(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, "en_mid");
         begin
            repeat (3) @(negedge tb_clk);
            enable = 1'b0;
         end
      join
      enable = 1'b1;

      // Asynchronous reset in the middle of a data bit
      send_byte(0, 8'h00, "rst");
      repeat (25) @(negedge tb_clk);
      chk("rst_pre_tx", 32'(tx_w[0]), 32'd0);
      #1 nrst = 1'b0;
      #1;
      chk("rst_async_tx",    32'(tx_w[0]),  32'd1);
      chk("rst_async_ready", 32'(dr_w[0]),  32'd1);
      chk("rst_async_trans", 32'(tr_w[0]),  32'd0);
      chk("rst_async_bits",  32'(bs_w[0]),  32'd0);
      chk("rst_async_baud",  32'(bc_w[0]),  32'd0);
      chk("rst_async_done",  32'(done_w[0]), 32'd0);
      @(negedge tb_clk);
      nrst = 1'b1;
      errs = 0;
      repeat (3*11*C) begin
         @(negedge tb_clk);
         if (tx_w[0] !== 1'b1 || done_w[0] !== 1'b0 || tr_w[0] !== 1'b0) errs++;
      end
      chk("rst_no_resume", 32'(errs), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
